// File: rtl/lisnoc_router_output_arbiter_pkg.sv
// Shared types for the router output arbiter: flit type codes and arbiter FSM states.
// Flit type codes match the router-wide flit definitions.
package lisnoc_router_output_arbiter_pkg;

    localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
    localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lisnoc_arb_rr.sv
// Combinational round-robin arbiter: the first requester at or above the one-hot ptr wins,
// wrapping upward modulo N.
module lisnoc_arb_rr #(
    parameter int N = 5
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] gnt
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] first;

    always_comb begin
        // Lower copy holds only requests at or above ptr; the upper copy provides the wrap.
        mask  = ~(ptr - {{(N-1){1'b0}}, 1'b1});
        dbl   = {req, req & mask};
        first = dbl & ~(dbl - {{(2*N-1){1'b0}}, 1'b1});
        gnt   = first[N-1:0] | first[2*N-1:N];
    end

endmodule

// File: rtl/lisnoc_router_output_arbiter.sv
// Output-port stage: round-robin arbitration with per-packet lock, read acknowledge
// back to the winning input, and a registered output flit with valid/ready handshake.
module lisnoc_router_output_arbiter
    import lisnoc_router_output_arbiter_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ports           = 5
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [ports-1:0]                                       in_request,
    input  logic [ports*(flit_data_width+flit_type_width)-1:0]     in_flit,
    output logic [ports-1:0]                                       in_read,
    output logic [flit_data_width+flit_type_width-1:0]             out_flit,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output arb_state_t                                             dbg_state,
    output logic [ports-1:0]                                       dbg_rr_ptr,
    output logic [ports-1:0]                                       dbg_lock_port
);

    localparam int flit_width = flit_data_width + flit_type_width;

    // Handshake: out_flit moves downstream on any cycle with out_valid && out_ready;
    // input i's flit is taken on any cycle with in_read[i], and appears one cycle later.
    arb_state_t              state_q, state_d;
    logic [ports-1:0]        lock_port_q, lock_port_d;
    logic [ports-1:0]        rr_ptr_q, rr_ptr_d;
    logic [flit_width-1:0]   out_flit_q, out_flit_d;
    logic                    out_valid_q, out_valid_d;

    logic                        can_accept;
    logic [ports-1:0]            rr_gnt;
    logic [ports-1:0]            grant;
    logic [ports-1:0]            read;
    logic                        transfer;
    logic [flit_width-1:0]       sel_flit;
    logic [flit_type_width-1:0]  sel_type;

    lisnoc_arb_rr #(
        .N (ports)
    ) u_arb (
        .req (in_request),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt)
    );

    always_comb begin
        can_accept = ~out_valid_q | out_ready;
        grant      = (state_q == ARB_LOCKED) ? lock_port_q : rr_gnt;
        read       = can_accept ? (grant & in_request) : '0;
        transfer   = |read;

        sel_flit = '0;
        for (int i = 0; i < ports; i++) begin
            if (read[i]) begin
                sel_flit = sel_flit | in_flit[i*flit_width +: flit_width];
            end
        end
        sel_type = sel_flit[flit_width-1 -: flit_type_width];

        state_d     = state_q;
        lock_port_d = lock_port_q;
        rr_ptr_d    = rr_ptr_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;

        if (transfer) begin
            out_flit_d  = sel_flit;
            out_valid_d = 1'b1;
            if (state_q == ARB_IDLE) begin
                // Anything but a HEADER while unlocked is treated as a single-flit packet.
                if (sel_type == FLIT_TYPE_HEADER) begin
                    state_d     = ARB_LOCKED;
                    lock_port_d = read;
                end else begin
                    rr_ptr_d = {read[ports-2:0], read[ports-1]};
                end
            end else if (sel_type == FLIT_TYPE_LAST) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = {lock_port_q[ports-2:0], lock_port_q[ports-1]};
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            lock_port_q <= '0;
            rr_ptr_q    <= {{(ports-1){1'b0}}, 1'b1};
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_port_q <= lock_port_d;
            rr_ptr_q    <= rr_ptr_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_read       = read;
    assign out_flit      = out_flit_q;
    assign out_valid     = out_valid_q;
    assign dbg_state     = state_q;
    assign dbg_rr_ptr    = rr_ptr_q;
    assign dbg_lock_port = lock_port_q;

endmodule

// File: tb/tb_lisnoc_router_output_arbiter.sv
// Bench for the router output arbiter: per-port flit sources, a port-index behavioural
// model with an expected-output queue, a per-cycle compare process and directed tests.
module tb_lisnoc_router_output_arbiter;
    import lisnoc_router_output_arbiter_pkg::*;

    localparam int FW = 34;
    localparam int NP = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     in_request;
    logic [NP*FW-1:0]  in_flit;
    logic [NP-1:0]     in_read;
    logic [FW-1:0]     out_flit;
    logic              out_valid;
    logic              out_ready;
    arb_state_t        dbg_state;
    logic [NP-1:0]     dbg_rr_ptr;
    logic [NP-1:0]     dbg_lock_port;

    lisnoc_router_output_arbiter #(
        .flit_data_width (32),
        .flit_type_width (2),
        .ports           (NP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_request    (in_request),
        .in_flit       (in_flit),
        .in_read       (in_read),
        .out_flit      (out_flit),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .dbg_state     (dbg_state),
        .dbg_rr_ptr    (dbg_rr_ptr),
        .dbg_lock_port (dbg_lock_port)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
        return {t, d};
    endfunction

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    // ---------------- flit sources ----------------
    logic [FW-1:0] src_q [NP][$];
    bit            hold [NP];
    int            grant_log[$];
    logic [NP-1:0] last_rd;

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            in_request[p] = (src_q[p].size() > 0) && !hold[p];
            in_flit[p*FW +: FW] = (src_q[p].size() > 0) ? src_q[p][0] : '0;
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        last_rd = in_read;
        for (int p = 0; p < NP; p++) if (last_rd[p]) grant_log.push_back(p);
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (last_rd[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        end
    endtask

    task automatic clear_sources();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            hold[p] = 1'b0;
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            started = 1'b0;
    bit            m_valid = 1'b0;
    logic [FW-1:0] m_flit  = '0;
    bit            m_locked = 1'b0;
    int            m_lock = 0;
    int            m_ptr  = 0;
    logic [FW-1:0] exp_q[$];

    function automatic int model_grant();
        if (m_valid && !out_ready) return -1;
        if (m_locked) return in_request[m_lock] ? m_lock : -1;
        for (int k = 0; k < NP; k++) begin
            if (in_request[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int            g;
        logic [FW-1:0] f;
        g = model_grant();
        started = 1'b1;
        if (rst) begin
            m_valid  = 1'b0;
            m_flit   = '0;
            m_locked = 1'b0;
            m_lock   = 0;
            m_ptr    = 0;
            exp_q.delete();
        end else begin
            if (m_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (g >= 0) begin
                f = in_flit[g*FW +: FW];
                m_flit  = f;
                m_valid = 1'b1;
                exp_q.push_back(f);
                if (!m_locked) begin
                    if (f[FW-1 -: 2] == FLIT_TYPE_HEADER) begin
                        m_locked = 1'b1;
                        m_lock   = g;
                    end else begin
                        m_ptr = (g + 1) % NP;
                    end
                end else if (f[FW-1 -: 2] == FLIT_TYPE_LAST) begin
                    m_locked = 1'b0;
                    m_ptr    = (m_lock + 1) % NP;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        if (started) begin
            g = model_grant();
            check("in_read", in_read, onehot(g));
            check("in_read_onehot", 64'($countones(in_read) <= 1), 1);
            check("out_valid", out_valid, m_valid);
            check("out_flit", out_flit, m_flit);
            check("state", dbg_state, m_locked ? ARB_LOCKED : ARB_IDLE);
            check("rr_ptr", dbg_rr_ptr, onehot(m_ptr));
            if (m_locked) check("lock_port", dbg_lock_port, onehot(m_lock));
            if (m_valid && out_ready) begin
                check("handoff_pending", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("handoff", out_flit, exp_q[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int t2 [6] = '{0, 0, 0, 3, 3, 3};
        int t3 [3] = '{1, 1, 4};

        rst        = 1'b1;
        out_ready  = 1'b1;
        in_request = '0;
        in_flit    = '0;
        clear_sources();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_rr_ptr", dbg_rr_ptr, 5'b00001);
        check("rst_state", dbg_state, ARB_IDLE);
        rst = 1'b0;

        // 1: single flit on port 2
        src_q[2].push_back(mk(FLIT_TYPE_SINGLE, 32'h0000_00AA));
        cycle();
        check("t1_in_read", last_rd, 5'b00100);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_flit", out_flit, 34'h3_0000_00AA);
        check("t1_rr_ptr", dbg_rr_ptr, 5'b01000);
        src_q[4].push_back(mk(FLIT_TYPE_SINGLE, 32'h4A));
        cycle();
        check("t1_rr_wrap", dbg_rr_ptr, 5'b00001);

        // 2: two three-flit packets, port 0 first
        grant_log.delete();
        src_q[0].push_back(mk(FLIT_TYPE_HEADER,  32'h100));
        src_q[0].push_back(mk(FLIT_TYPE_PAYLOAD, 32'h101));
        src_q[0].push_back(mk(FLIT_TYPE_LAST,    32'h102));
        src_q[3].push_back(mk(FLIT_TYPE_HEADER,  32'h300));
        src_q[3].push_back(mk(FLIT_TYPE_PAYLOAD, 32'h301));
        src_q[3].push_back(mk(FLIT_TYPE_LAST,    32'h302));
        repeat (6) cycle();
        check("t2_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) check("t2_grant", grant_log[i], t2[i]);
        check("t2_out_flit", out_flit, 34'h2_0000_0302);
        check("t2_rr_ptr", dbg_rr_ptr, 5'b10000);

        // 3: locked port 1 bubbles while port 4 waits
        grant_log.delete();
        src_q[1].push_back(mk(FLIT_TYPE_HEADER, 32'h110));
        src_q[1].push_back(mk(FLIT_TYPE_LAST,   32'h111));
        cycle();
        check("t3_locked", dbg_state, ARB_LOCKED);
        check("t3_lock_port", dbg_lock_port, 5'b00010);
        hold[1] = 1'b1;
        src_q[4].push_back(mk(FLIT_TYPE_SINGLE, 32'h4B));
        repeat (2) begin
            cycle();
            check("t3_bubble", last_rd, 5'b00000);
        end
        check("t3_bubble_valid", out_valid, 0);
        hold[1] = 1'b0;
        repeat (2) cycle();
        check("t3_count", grant_log.size(), 3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++) check("t3_grant", grant_log[i], t3[i]);
        check("t3_out_flit", out_flit, 34'h3_0000_004B);
        check("t3_rr_ptr", dbg_rr_ptr, 5'b00001);

        // 4: backpressure, then full throughput
        for (int k = 1; k <= 5; k++) src_q[0].push_back(mk(FLIT_TYPE_SINGLE, 32'h500 + k));
        cycle();
        out_ready = 1'b0;
        repeat (4) begin
            cycle();
            check("t4_stall_read", last_rd, 5'b00000);
            check("t4_stall_flit", out_flit, 34'h3_0000_0501);
            check("t4_stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        grant_log.delete();
        repeat (4) begin
            cycle();
            check("t4_stream_read", last_rd, 5'b00001);
        end
        check("t4_count", grant_log.size(), 4);
        check("t4_out_flit", out_flit, 34'h3_0000_0505);

        // 5: all ports requesting single flits
        src_q[4].push_back(mk(FLIT_TYPE_SINGLE, 32'h4C));
        cycle();
        check("t5_rr_start", dbg_rr_ptr, 5'b00001);
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 2; k++) src_q[p].push_back(mk(FLIT_TYPE_SINGLE, 32'h700 + p*16 + k));
        end
        grant_log.delete();
        repeat (10) cycle();
        check("t5_count", grant_log.size(), 10);
        for (int i = 0; i < 10 && i < grant_log.size(); i++) check("t5_grant", grant_log[i], i % NP);

        // 6: reset in the middle of a locked packet on port 2
        src_q[2].push_back(mk(FLIT_TYPE_HEADER,  32'h800));
        src_q[2].push_back(mk(FLIT_TYPE_PAYLOAD, 32'h801));
        src_q[2].push_back(mk(FLIT_TYPE_PAYLOAD, 32'h802));
        src_q[2].push_back(mk(FLIT_TYPE_LAST,    32'h803));
        cycle();
        check("t6_locked", dbg_state, ARB_LOCKED);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_sources();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_state", dbg_state, ARB_IDLE);
        check("t6_rst_ptr", dbg_rr_ptr, 5'b00001);
        src_q[0].push_back(mk(FLIT_TYPE_SINGLE, 32'h900));
        src_q[2].push_back(mk(FLIT_TYPE_SINGLE, 32'h901));
        cycle();
        check("t6_first_read", last_rd, 5'b00001);
        check("t6_first_flit", out_flit, 34'h3_0000_0900);
        cycle();
        check("t6_second_read", last_rd, 5'b00100);
        cycle();
        check("t6_drain_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
